gir_wb_sched: RTL and testbench

//  Writeback scheduler and scoreboard for the general integer register file (GIR). Shares the single
//  GIR write port between two writeback requesters (EXU, LSU) with round-robin arbitration.

---
 rtl/gir_wb_sched_pkg.sv | 25 ++
 rtl/gir_scoreboard.sv | 43 ++++
 rtl/gir_wb_sched.sv | 104 ++++++++++
 tb/tb_gir_wb_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gir_wb_sched_pkg.sv
// Shared types and constants for the GIR writeback scheduler and its scoreboard.
package gir_wb_sched_pkg;

  localparam int GIR_XLEN = 64;
  localparam int GIR_NREG = 32;
  localparam int IDX_W    = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;

  // Requester whose turn it is when both writeback paths are valid.
  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    reg_idx_t            rd;
    logic [GIR_XLEN-1:0] data;
  } wb_req_t;

  function automatic logic idx_nonzero(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/gir_scoreboard.sv
// Pending-write scoreboard for the GIR: one set port, one clear port, three read ports.
module gir_scoreboard
  import gir_wb_sched_pkg::*;
#(
  parameter int NREG = GIR_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_idx_t        set_idx,
  input  logic            clr_en,
  input  reg_idx_t        clr_idx,
  input  reg_idx_t        rs1_idx,
  input  reg_idx_t        rs2_idx,
  input  reg_idx_t        rd_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-edge collision leaves the register pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
  assign rd_busy  = busy_q[rd_idx];
  assign busy     = busy_q;

endmodule

// File: rtl/gir_wb_sched.sv
// GIR writeback scheduler: round-robin EXU/LSU arbitration onto the single GIR write port,
// plus issue hazard detection against the pending-write scoreboard.
module gir_wb_sched
  import gir_wb_sched_pkg::*;
#(
  parameter int XLEN = GIR_XLEN,
  parameter int NREG = GIR_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rs1,
  input  reg_idx_t        iss_rs2,
  input  reg_idx_t        iss_rd,
  input  logic            iss_rd_wen,
  output logic            iss_ready,
  input  logic            exu_wb_valid,
  input  reg_idx_t        exu_wb_rd,
  input  logic [XLEN-1:0] exu_wb_data,
  output logic            exu_wb_ready,
  input  logic            lsu_wb_valid,
  input  reg_idx_t        lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  output reg_idx_t        rd,
  output logic            rd_wen,
  output logic [XLEN-1:0] x_rd,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);

  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            hazard;
  logic            iss_fire;
  logic            sb_set_en;
  wb_src_e         rr_q;
  logic            exu_gnt;
  logic            lsu_gnt;
  logic            gnt_any;
  reg_idx_t        gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            gnt_write;

  gir_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set_en),
    .set_idx  (iss_rd),
    .clr_en   (rd_wen),
    .clr_idx  (rd),
    .rs1_idx  (iss_rs1),
    .rs2_idx  (iss_rs2),
    .rd_idx   (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy     (busy)
  );

  assign hazard    = rs1_busy | rs2_busy | (iss_rd_wen & rd_busy);
  assign iss_ready = ~hazard;
  assign iss_fire  = iss_valid & iss_ready;
  assign sb_set_en = iss_fire & iss_rd_wen & idx_nonzero(iss_rd);

  // A lone requester always wins; on contention rr_q names the one that did not win last.
  always_comb begin
    exu_gnt = exu_wb_valid & (~lsu_wb_valid | (rr_q == WB_EXU));
    lsu_gnt = lsu_wb_valid & ~exu_gnt;
    gnt_any = exu_gnt | lsu_gnt;
    if (exu_gnt) begin
      gnt_rd   = exu_wb_rd;
      gnt_data = exu_wb_data;
    end else begin
      gnt_rd   = lsu_wb_rd;
      gnt_data = lsu_wb_data;
    end
    gnt_write = gnt_any & idx_nonzero(gnt_rd);
  end

  assign exu_wb_ready = exu_gnt;
  assign lsu_wb_ready = lsu_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q   <= WB_EXU;
      rd     <= '0;
      rd_wen <= 1'b0;
      x_rd   <= '0;
      wb_err <= 1'b0;
    end else begin
      rd_wen <= gnt_write;
      if (gnt_any) rr_q <= exu_gnt ? WB_LSU : WB_EXU;
      if (gnt_write) begin
        rd   <= gnt_rd;
        x_rd <= gnt_data;
      end
      // Writing a register nobody was waiting on means the pipeline lost track of ownership.
      if (gnt_write && !busy[gnt_rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gir_wb_sched.sv
// Scoreboard bench for gir_wb_sched: directed scenarios plus randomized traffic checked
// against a pending-register model and a queue of expected GIR writes.
module tb_gir_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rd_wen;
  logic        iss_ready;
  logic        exu_wb_valid;
  logic [4:0]  exu_wb_rd;
  logic [63:0] exu_wb_data;
  logic        exu_wb_ready;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [63:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic [4:0]  rd;
  logic        rd_wen;
  logic [63:0] x_rd;
  logic [31:0] busy;
  logic        wb_err;

  always #5 clk = ~clk;

  gir_wb_sched dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_rd_wen   (iss_rd_wen),
    .iss_ready    (iss_ready),
    .exu_wb_valid (exu_wb_valid),
    .exu_wb_rd    (exu_wb_rd),
    .exu_wb_data  (exu_wb_data),
    .exu_wb_ready (exu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .rd           (rd),
    .rd_wen       (rd_wen),
    .x_rd         (x_rd),
    .busy         (busy),
    .wb_err       (wb_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: set of registers with an outstanding write, sticky error,
  // whose turn it is on contention, and the write currently on the GIR port.
  logic [31:0] m_busy;
  logic        m_err;
  bit          m_lsu_pri;
  bit          m_wr_v;
  logic [4:0]  m_wr_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Write-port monitor: every rd_wen pulse must match the oldest expected write, on time.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_wen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got rd_wen=1 rd=%0d, expected no write (cycle %0d)", rd, cyc);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(w.due));
          chk("wr_rd", 64'(rd), 64'(w.rd));
          chk("wr_data", x_rd, w.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL wr_missing: got rd_wen=0, expected write rd=%0d (cycle %0d)", exp_q[0].rd, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    m_busy    = '0;
    m_err     = 1'b0;
    m_lsu_pri = 1'b0;
    m_wr_v    = 1'b0;
    m_wr_rd   = '0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_wen = 0;
    exu_wb_valid = 0; exu_wb_rd = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  // One clock cycle: called 1 time unit after a rising edge, returns 1 after the next one.
  task automatic step(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rdi, input bit wen,
                      input bit ev, input logic [4:0] erd, input logic [63:0] ed,
                      input bit lv, input logic [4:0] lrd, input logic [63:0] ld,
                      output bit eg, output bit lg);
    logic        hz;
    logic [4:0]  g_rd;
    logic [63:0] g_d;
    logic [31:0] nb;
    iss_valid = iv; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rdi; iss_rd_wen = wen;
    exu_wb_valid = ev; exu_wb_rd = erd; exu_wb_data = ed;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
    #2;
    hz = m_busy[r1] | m_busy[r2] | (wen & m_busy[rdi]);
    eg = ev && (!lv || !m_lsu_pri);
    lg = lv && !eg;
    chk("iss_ready", 64'(iss_ready), 64'(!hz));
    chk("exu_ready", 64'(exu_wb_ready), 64'(eg));
    chk("lsu_ready", 64'(lsu_wb_ready), 64'(lg));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("wb_err", 64'(wb_err), 64'(m_err));
    nb = m_busy;
    if (m_wr_v) nb[m_wr_rd] = 1'b0;
    if (iv && !hz && wen && rdi != 0) nb[rdi] = 1'b1;
    m_wr_v = 1'b0;
    if (eg || lg) begin
      g_rd = eg ? erd : lrd;
      g_d  = eg ? ed : ld;
      m_lsu_pri = eg;
      if (g_rd != 0) begin
        exp_q.push_back('{due: cyc + 1, rd: g_rd, data: g_d});
        if (!m_busy[g_rd]) m_err = 1'b1;
        m_wr_v  = 1'b1;
        m_wr_rd = g_rd;
      end
    end
    @(posedge clk);
    m_busy = nb;
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi, input bit wen);
    bit a, b;
    step(1, r1, r2, rdi, wen, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_wen", 64'(rd_wen), 64'd0);
    chk("rst_wb_err", 64'(wb_err), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_x_rd", x_rd, 64'd0);
    model_clear();
    drive_idle();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int t = 0; t < 8; t++) begin
      r = 5'($urandom_range(1, 31));
      if (m_busy[r]) return r;
    end
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic random_traffic(input int n);
    bit eg, lg, ev_h, lv_h;
    logic [4:0]  erh, lrh;
    logic [63:0] edh, ldh;
    ev_h = 0; lv_h = 0; erh = 0; lrh = 0; edh = 0; ldh = 0;
    for (int i = 0; i < n; i++) begin
      if (!ev_h && $urandom_range(0, 2) == 0) begin
        ev_h = 1; erh = pick_rd(); edh = {$urandom, $urandom};
      end
      if (!lv_h && $urandom_range(0, 2) == 0) begin
        lv_h = 1; lrh = pick_rd(); ldh = {$urandom, $urandom};
      end
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
           ev_h, erh, edh, lv_h, lrh, ldh, eg, lg);
      if (eg) ev_h = 0;
      if (lg) lv_h = 0;
    end
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit eg, lg;
    int ei, li;
    logic [4:0]  er [2];
    logic [4:0]  lr [2];
    logic [63:0] ed [2];
    logic [63:0] ld [2];

    rst = 1'b0;
    drive_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Producer/consumer on x5: consumer stalls until the cycle after the writeback.
    issue(0, 0, 5, 1);
    issue(5, 0, 0, 0);
    step(1, 5, 0, 0, 0, 1, 5, 64'hABCD, 0, 0, 0, eg, lg);
    chk("sc1_exu_gnt", 64'(exu_wb_ready), 64'd1);
    issue(5, 0, 0, 0);
    issue(5, 0, 0, 0);
    idle(2);

    random_traffic(1500);

    do_reset();

    // Contention after reset: EXU first, then strict alternation.
    issue(0, 0, 3, 1);
    issue(0, 0, 4, 1);
    issue(0, 0, 13, 1);
    issue(0, 0, 14, 1);
    er = '{5'd3, 5'd13};
    lr = '{5'd4, 5'd14};
    ed = '{{$urandom, $urandom}, {$urandom, $urandom}};
    ld = '{{$urandom, $urandom}, {$urandom, $urandom}};
    ei = 0;
    li = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, ei < 2, er[ei % 2], ed[ei % 2], li < 2, lr[li % 2], ld[li % 2], eg, lg);
      if (eg) ei++;
      if (lg) li++;
    end
    idle(2);

    // x0 destination: never marked busy, grant accepted without a port write.
    issue(0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 64'h1234, 0, 0, 0, eg, lg);
    idle(2);

    // Writeback to an idle register: performed, error flag sticks.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 64'h77, eg, lg);
    idle(4);

    // WAW on x9.
    issue(0, 0, 9, 1);
    issue(0, 0, 9, 1);
    issue(0, 0, 9, 1);
    step(1, 0, 0, 9, 1, 0, 0, 0, 1, 9, 64'h99, eg, lg);
    issue(0, 0, 9, 1);
    issue(0, 0, 9, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 64'h999, eg, lg);
    idle(3);

    random_traffic(500);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
